// File: rtl/timer_pkg.sv
// Shared types and constants for the programmable seconds timer.
//   timer_state_t : FSM state encoding (IDLE, RUN, PAUSED, DONE)
//   MODE_ONESHOT / MODE_PERIODIC : value of the latched "periodic" input
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } timer_state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/sec_prescaler.sv
// Divides clk down to a one-cycle tick once per second.
// Ports:
//   clk  in  system clock
//   rst  in  synchronous, active-high reset (count <= 0)
//   clr  in  synchronous clear (count <= 0), used on (re)start
//   en   in  count enable; the count holds while low
//   tick out high in the cycle the count sits at CLOCK_FREQ-1 while en
module sec_prescaler #(
    parameter int unsigned CLOCK_FREQ = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned CNT_W = (CLOCK_FREQ > 1) ? $clog2(CLOCK_FREQ) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(CLOCK_FREQ - 1);

    logic [CNT_W-1:0] count;

    assign tick = en && (count == TERM);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            if (count == TERM) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seconds_timer.sv
// Programmable seconds timer with pause/resume, one-shot or periodic mode.
// Optional feature: define SECONDS_OUT_EN to expose secs_left.
// Ports:
//   clk       in   system clock
//   rst       in   synchronous, active-high reset
//   start     in   1-cycle pulse: latch duration/periodic and (re)start
//   pause     in   level: freeze the countdown while high (RUN only)
//   periodic  in   sampled at start: 0 one-shot, 1 auto-reload
//   duration  in   seconds to count, sampled at start
//   busy      out  high in RUN or PAUSED
//   timeout   out  level: one-shot completed, held until start or rst
//   expire    out  1-cycle pulse at each expiry
//   secs_left out  remaining whole seconds (SECONDS_OUT_EN only)
module seconds_timer
    import timer_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 100_000_000,
    parameter int unsigned SEC_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pause,
    input  logic             periodic,
    input  logic [SEC_W-1:0] duration,
    output logic             busy,
    output logic             timeout,
    output logic             expire
`ifdef SECONDS_OUT_EN
    ,
    output logic [SEC_W-1:0] secs_left
`endif
);

    timer_state_t     state;
    logic [SEC_W-1:0] remaining;
    logic [SEC_W-1:0] dur_q;
    logic             mode_q;
    logic             sec_tick;

    sec_prescaler #(
        .CLOCK_FREQ(CLOCK_FREQ)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (start),
        .en   (state == RUN),
        .tick (sec_tick)
    );

`ifdef SECONDS_OUT_EN
    // remaining is itself a register and is already 0 outside RUN/PAUSED,
    // so it is exposed directly.
    assign secs_left = remaining;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            dur_q     <= '0;
            mode_q    <= MODE_ONESHOT;
            busy      <= 1'b0;
            timeout   <= 1'b0;
            expire    <= 1'b0;
        end else begin
            expire <= 1'b0;
            if (start) begin
                // start wins over pause and over a coincident expiry
                dur_q     <= duration;
                mode_q    <= periodic;
                remaining <= duration;
                if (duration == '0) begin
                    state   <= DONE;
                    busy    <= 1'b0;
                    expire  <= 1'b1;
                    timeout <= 1'b1;
                end else begin
                    state   <= RUN;
                    busy    <= 1'b1;
                    timeout <= 1'b0;
                end
            end else begin
                case (state)
                    RUN: begin
                        // the prescaler still counts in the cycle pause is first
                        // seen, so a tick landing there must be honoured
                        if (sec_tick && remaining == SEC_W'(1)) begin
                            expire <= 1'b1;
                            if (mode_q == MODE_PERIODIC) begin
                                remaining <= dur_q;
                                state     <= pause ? PAUSED : RUN;
                            end else begin
                                remaining <= '0;
                                state     <= DONE;
                                busy      <= 1'b0;
                                timeout   <= 1'b1;
                            end
                        end else begin
                            if (sec_tick && remaining > SEC_W'(1)) begin
                                remaining <= remaining - 1'b1;
                            end
                            if (pause) begin
                                state <= PAUSED;
                            end
                        end
                    end
                    PAUSED: begin
                        if (!pause) begin
                            state <= RUN;
                        end
                    end
                    default: begin
                        // IDLE and DONE only leave on start
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seconds_timer.sv
module tb_seconds_timer;
    import timer_pkg::*;

    localparam int unsigned CF = 10;
    localparam int unsigned SW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          pause = 1'b0;
    logic          periodic = 1'b0;
    logic [SW-1:0] duration = '0;
    logic          busy;
    logic          timeout;
    logic          expire;
`ifdef SECONDS_OUT_EN
    logic [SW-1:0] secs_left;
`endif

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int exp_at[$];

    seconds_timer #(
        .CLOCK_FREQ(CF),
        .SEC_W(SW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .pause    (pause),
        .periodic (periodic),
        .duration (duration),
        .busy     (busy),
        .timeout  (timeout),
        .expire   (expire)
`ifdef SECONDS_OUT_EN
        ,
        .secs_left(secs_left)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // advance n edges, sampling 1 time unit after each, logging expire pulses
    task automatic adv(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (expire) exp_at.push_back(cyc);
        end
    endtask

    // start sampled at edge E0; cyc=0 denotes the cycle after E0
    task automatic do_start(input logic [SW-1:0] d, input logic p);
        start = 1'b1;
        duration = d;
        periodic = p;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        exp_at.delete();
        if (expire) exp_at.push_back(0);
    endtask

    initial begin
        // 1. reset
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy", 32'(busy), 0);
        check("rst_timeout", 32'(timeout), 0);
        check("rst_expire", 32'(expire), 0);
        check("rst_state", 32'(dut.state), 32'(IDLE));
        check("rst_remaining", 32'(dut.remaining), 0);
`ifdef SECONDS_OUT_EN
        check("rst_secs_left", 32'(secs_left), 0);
`endif
        // pause in IDLE has no effect
        pause = 1'b1;
        adv(3);
        pause = 1'b0;
        check("idle_pause_busy", 32'(busy), 0);

        // 2. one-shot 3 s
        do_start(4'd3, 1'b0);
        check("os_busy_after_start", 32'(busy), 1);
`ifdef SECONDS_OUT_EN
        check("os_secs_left_start", 32'(secs_left), 3);
`endif
        adv(35);
        check("os_expire_count", 32'(exp_at.size()), 1);
        check("os_expire_at", 32'(exp_at[0]), 30);
        check("os_timeout", 32'(timeout), 1);
        check("os_busy_done", 32'(busy), 0);
        check("os_state_done", 32'(dut.state), 32'(DONE));

        // 3. periodic 2 s
        do_start(4'd2, 1'b1);
        check("per_timeout_cleared", 32'(timeout), 0);
        adv(65);
        check("per_expire_count", 32'(exp_at.size()), 3);
        check("per_expire_1", 32'(exp_at[0]), 20);
        check("per_expire_2", 32'(exp_at[1]), 40);
        check("per_expire_3", 32'(exp_at[2]), 60);
        check("per_timeout", 32'(timeout), 0);
        check("per_busy", 32'(busy), 1);

        // 4. pause 7 cycles from cycle 15 of a 3 s one-shot
        do_start(4'd3, 1'b0);
        adv(14);
        pause = 1'b1;
        adv(7);
        check("pause_remaining", 32'(dut.remaining), 2);
        check("pause_state", 32'(dut.state), 32'(PAUSED));
        check("pause_busy", 32'(busy), 1);
`ifdef SECONDS_OUT_EN
        check("pause_secs_left", 32'(secs_left), 2);
`endif
        pause = 1'b0;
        adv(20);
        check("pause_expire_count", 32'(exp_at.size()), 1);
        check("pause_expire_at", 32'(exp_at[0]), 37);

        // 5. restart at cycle 25 of a 3 s run
        do_start(4'd3, 1'b0);
        adv(24);
        check("restart_no_early", 32'(exp_at.size()), 0);
        do_start(4'd3, 1'b0);
        adv(35);
        check("restart_expire_count", 32'(exp_at.size()), 1);
        check("restart_expire_at", 32'(exp_at[0]), 30);

        // duration 0: immediate expiry
        do_start(4'd0, 1'b1);
        check("zero_expire", 32'(expire), 1);
        check("zero_timeout", 32'(timeout), 1);
        check("zero_busy", 32'(busy), 0);
        adv(1);
        check("zero_expire_pulse", 32'(expire), 0);
        check("zero_timeout_held", 32'(timeout), 1);

        // 6. reset at cycle 12 of a run
        do_start(4'd3, 1'b0);
        adv(11);
        rst = 1'b1;
        adv(1);
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_timeout", 32'(timeout), 0);
        check("midrst_state", 32'(dut.state), 32'(IDLE));
        adv(40);
        check("midrst_no_expire", 32'(exp_at.size()), 0);
        check("midrst_expire", 32'(expire), 0);

        // start with pause: one RUN cycle (one prescaler count), then PAUSED
        pause = 1'b1;
        do_start(4'd3, 1'b0);
        check("sp_state_run", 32'(dut.state), 32'(RUN));
        adv(1);
        check("sp_state_paused", 32'(dut.state), 32'(PAUSED));
        adv(48);
        check("sp_no_expire", 32'(exp_at.size()), 0);
        check("sp_busy", 32'(busy), 1);
        pause = 1'b0;
        adv(40);
        check("sp_expire_count", 32'(exp_at.size()), 1);
        check("sp_expire_at", 32'(exp_at[0]), 79);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
